filter_sample_pacer: RTL

- Source side of the filter sample interface (`X` / `en`) used by the FIR and IIR filter blocks.
- Buffers 16-bit samples written by the host or bus side in a small FIFO.
- Presents them to the filters one at a time, with a single-cycle `en` strobe at a programmable period.
- Sits directly in front of the filter instances and drives their `X` and `en` inputs.

---
 rtl/filter_sample_pacer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/filter_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module   : filter_sample_pacer
// Brief    : Sample source for the FIR/IIR filter blocks. Buffers host-written
//            samples in a small circular FIFO and presents them on X with a
//            one-cycle en strobe every (div+1) clocks while run is high.
// Revision : 1.0 - initial release
// ============================================================================
module filter_sample_pacer #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [N-1:0]             wr_data,
    input  logic                     run,
    input  logic [DIV_W-1:0]         div,
    input  logic                     flush,
    input  logic                     clear_flags,
    output logic [N-1:0]             X,
    output logic                     en,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     underrun,
    output logic                     overflow
);

    localparam int                    c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w:0]     c_depth   = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0]     c_lvl_one = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0]   c_ptr_one = c_addr_w'(1);
    localparam logic [DIV_W-1:0]      c_cnt_one = DIV_W'(1);

    // Storage and state
    logic [N-1:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_wptr;
    logic [c_addr_w-1:0]   r_rptr;
    logic [c_addr_w:0]     r_level;
    logic [DIV_W-1:0]      r_cnt;
    logic                  r_run_q;
    logic [N-1:0]          r_x;
    logic                  r_en;
    logic                  r_underrun;
    logic                  r_overflow;

    // Decoded per-cycle events
    logic w_rise;
    logic w_slot;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A run rising edge only (re)loads the divider; slots need run held
    // high across two edges, so the first strobe lands div+1 cycles later.
    assign w_rise  = run & ~r_run_q;
    assign w_slot  = run & r_run_q & (r_cnt == '0);
    assign w_empty = (r_level == '0);
    // Flush wins over both a pop and a push in the same cycle. A flush-dropped
    // write is intentional and is not reported as overflow.
    assign w_pop   = w_slot & ~w_empty & ~flush;
    assign w_push  = wr_en & ~flush & ((r_level != c_depth) | w_pop);
    assign w_drop  = wr_en & ~flush & ~w_push;

    assign X        = r_x;
    assign en       = r_en;
    assign level    = r_level;
    assign full     = (r_level == c_depth);
    assign empty    = w_empty;
    assign underrun = r_underrun;
    assign overflow = r_overflow;

    // Previous-cycle copy of run for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_q <= 1'b0;
        end else begin
            r_run_q <= run;
        end
    end

    // Period counter: load on run edge, count down, reload on each slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= div;
        end else if (run) begin
            if (r_cnt == '0) begin
                r_cnt <= div;
            end else begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    // Sample storage; contents need no reset since pointers gate all reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^k)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Output register: X and en change together so X is valid during en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x  <= '0;
            r_en <= 1'b0;
        end else begin
            r_en <= w_pop;
            if (w_pop) begin
                r_x <= r_mem[r_rptr];
            end
        end
    end

    // Sticky status flags; a set event beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_slot & w_empty) begin
                r_underrun <= 1'b1;
            end else if (clear_flags) begin
                r_underrun <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
